mem_lsu: RTL and testbench

//  Parametrised multi-cycle MEM stage; sits between ex_mem and mem_wb.

---
 rtl/mem_lsu_pkg.sv | 20 ++
 rtl/mem_lsu_fmt.sv | 33 +++
 rtl/mem_lsu.sv | 123 ++++++++++++
 tb/tb_mem_lsu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared opcodes, funct3 codes, FSM states and access-size decode for the MEM-stage LSU
package mem_lsu_pkg;
    localparam int REG_AW = 5;
    localparam logic [2:0] OP_OTHER = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef logic [2:0] mem_size_t;
    typedef enum logic {LSU_IDLE = 1'b0, LSU_BUSY = 1'b1} lsu_state_e;
    // Access size in bytes; 0 marks an encoding with no memory access (unsigned forms are load-only)
    function automatic mem_size_t mem_size(input logic [2:0] f3, input logic st);
        return (f3 == F3_B || (!st && f3 == F3_BU)) ? 3'd1 :
               (f3 == F3_H || (!st && f3 == F3_HU)) ? 3'd2 :
               (f3 == F3_W) ? 3'd4 : 3'd0;
    endfunction
endpackage

// File: rtl/mem_lsu_fmt.sv
// mem_lsu_fmt: combinational store-lane slicing, byte-enable generation and load extension
module mem_lsu_fmt
    import mem_lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int BUS_W = 8,
    localparam int BB   = BUS_W / 8
) (
    input  logic [2:0]       i_funct3,
    input  mem_size_t        i_size,
    input  logic [1:0]       i_beat,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [XLEN-1:0]  i_acc,
    output logic             o_last,
    output logic [BUS_W-1:0] o_mwdata,
    output logic [BB-1:0]    o_mbe,
    output logic [XLEN-1:0]  o_ldata
);
    int w_nbeats;
    int w_rem;
    // Beat count, remaining lanes on this beat, write slice and sign/zero extension of the gathered word
    always_comb begin
        w_nbeats = (int'(i_size) + BB - 1) / BB;
        w_rem    = int'(i_size) - int'(i_beat) * BB;
        o_last   = int'(i_beat) == w_nbeats - 1;
        o_mbe    = (w_rem >= BB) ? {BB{1'b1}} : BB'((1 << w_rem) - 1);
        o_mwdata = BUS_W'(i_wdata >> (int'(i_beat) * BUS_W));
        o_ldata  = (i_funct3 == F3_B)  ? {{(XLEN-8){i_acc[7]}}, i_acc[7:0]} :
                   (i_funct3 == F3_H)  ? {{(XLEN-16){i_acc[15]}}, i_acc[15:0]} :
                   (i_funct3 == F3_BU) ? {{(XLEN-8){1'b0}}, i_acc[7:0]} :
                   (i_funct3 == F3_HU) ? {{(XLEN-16){1'b0}}, i_acc[15:0]} : i_acc;
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: multi-cycle MEM stage with beat-wise req/ack memory port; optional MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 8,
    localparam int BB    = BUS_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [2:0]        aluop_i,
    input  logic [2:0]        alufunct3_i,
    input  logic [ADDR_W-1:0] maddr_i,
    input  logic              wreg_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              stallreq_o,
    output logic              mreq_o,
    output logic              mwe_o,
    output logic [ADDR_W-1:0] maddr_o,
    output logic [BUS_W-1:0]  mwdata_o,
    output logic [BB-1:0]     mbe_o,
    input  logic              mack_i,
    input  logic [BUS_W-1:0]  mrdata_i,
    output logic              valid_o,
    output logic              wreg_o,
    output logic [REG_AW-1:0] wd_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              wreg_f,
    output logic [REG_AW-1:0] wd_f,
    output logic [XLEN-1:0]   wdata_f,
    output logic              excp_o
);
    lsu_state_e        r_state;
    logic [1:0]        r_beat;
    logic [XLEN-1:0]   r_acc;
    logic              r_valid, r_wreg, r_excp;
    logic [REG_AW-1:0] r_wd;
    logic [XLEN-1:0]   r_wdata;
    logic              w_is_ld, w_is_st, w_mem, w_mis, w_access, w_req, w_last, w_done;
    mem_size_t         w_size;
    logic [BUS_W-1:0]  w_mwdata;
    logic [BB-1:0]     w_mbe;
    logic [XLEN-1:0]   w_acc_nx, w_ldata;

    assign w_is_ld = aluop_i == OP_LOAD;
    assign w_is_st = aluop_i == OP_STORE;
    assign w_mem   = valid_i & (w_is_ld | w_is_st);
    assign w_size  = mem_size(alufunct3_i, w_is_st);
`ifdef MEM_MISALIGN_TRAP_EN
    assign w_mis   = w_mem & ((w_size == 3'd2 & maddr_i[0]) | (w_size == 3'd4 & |maddr_i[1:0]));
`else
    assign w_mis   = 1'b0;
`endif
    assign w_access = w_mem & (w_size != 3'd0) & ~w_mis;
    // Request is combinational from IDLE so the first beat can complete in the issue cycle; reset kills it at once
    assign w_req    = rst & ((r_state == LSU_BUSY) | w_access);
    assign w_done   = w_req & mack_i & w_last;
    // r_acc is zero in IDLE, so the in-flight beat can simply be OR-ed into its lanes
    assign w_acc_nx = r_acc | (XLEN'(mrdata_i) << (int'(r_beat) * BUS_W));

    assign stallreq_o = w_req & ~w_done;
    assign mreq_o     = w_req;
    assign mwe_o      = w_req & w_is_st;
    assign maddr_o    = w_req ? maddr_i + ADDR_W'(int'(r_beat) * BB) : '0;
    assign mwdata_o   = (w_req & w_is_st) ? w_mwdata : '0;
    assign mbe_o      = w_req ? w_mbe : '0;
    assign valid_o    = r_valid;
    assign wreg_o     = r_wreg;
    assign wd_o       = r_wd;
    assign wdata_o    = r_wdata;
    assign excp_o     = r_excp;
    assign wreg_f     = r_wreg & r_valid;
    assign wd_f       = r_wd;
    assign wdata_f    = r_wdata;

    mem_lsu_fmt #(.XLEN(XLEN), .BUS_W(BUS_W)) u_fmt (
        .i_funct3 (alufunct3_i),
        .i_size   (w_size),
        .i_beat   (r_beat),
        .i_wdata  (wdata_i),
        .i_acc    (w_acc_nx),
        .o_last   (w_last),
        .o_mwdata (w_mwdata),
        .o_mbe    (w_mbe),
        .o_ldata  (w_ldata)
    );

    // Beat FSM plus the mem_wb result register; a stalled cycle without completion emits a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LSU_IDLE;
            r_beat  <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_wreg  <= 1'b0;
            r_wd    <= '0;
            r_wdata <= '0;
            r_excp  <= 1'b0;
        end else begin
            if (w_req && mack_i) begin
                r_state <= w_last ? LSU_IDLE : LSU_BUSY;
                r_beat  <= w_last ? 2'd0 : r_beat + 2'd1;
                r_acc   <= w_last ? '0 : w_acc_nx;
            end else if (w_req) begin
                r_state <= LSU_BUSY;
            end
            if (w_done || !stallreq_o) begin
                r_valid <= valid_i;
                r_wreg  <= wreg_i & ~w_is_st & ~(w_mem & ~w_access);
                r_wd    <= wd_i;
                r_wdata <= (w_is_ld && w_access) ? w_ldata : wdata_i;
                r_excp  <= w_mis;
            end else begin
                r_valid <= 1'b0;
                r_wreg  <= 1'b0;
                r_excp  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed checks of mem_lsu at BUS_W=8 and BUS_W=16 against hand-computed results
module tb_mem_lsu;
    import mem_lsu_pkg::*;
    logic clk = 1'b0, rst = 1'b0;
    logic v8, v16, wreg_i;
    logic [2:0] aluop_i, f3_i;
    logic [31:0] maddr_i, wdata_i;
    logic [4:0] wd_i;
    logic stall8, mreq8, mwe8, mack8, valid8, wreg8, wregf8, excp8;
    logic [31:0] maddr8, wdata8, wdataf8;
    logic [7:0] mwdata8, mrdata8;
    logic [0:0] mbe8;
    logic [4:0] wd8, wdf8;
    logic stall16, mreq16, mwe16, mack16, valid16, wreg16, wregf16, excp16;
    logic [31:0] maddr16, wdata16, wdataf16;
    logic [15:0] mwdata16, mrdata16;
    logic [1:0] mbe16;
    logic [4:0] wd16, wdf16;
    logic [7:0] mem [0:1023];
    logic [7:0] wmem [0:1023];
    int dly8 = 0, wait8 = 0;
    logic force8 = 1'b0;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    mem_lsu #(.BUS_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .valid_i(v8), .aluop_i(aluop_i), .alufunct3_i(f3_i),
        .maddr_i(maddr_i), .wreg_i(wreg_i), .wd_i(wd_i), .wdata_i(wdata_i),
        .stallreq_o(stall8), .mreq_o(mreq8), .mwe_o(mwe8), .maddr_o(maddr8),
        .mwdata_o(mwdata8), .mbe_o(mbe8), .mack_i(mack8), .mrdata_i(mrdata8),
        .valid_o(valid8), .wreg_o(wreg8), .wd_o(wd8), .wdata_o(wdata8),
        .wreg_f(wregf8), .wd_f(wdf8), .wdata_f(wdataf8), .excp_o(excp8));

    mem_lsu #(.BUS_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .valid_i(v16), .aluop_i(aluop_i), .alufunct3_i(f3_i),
        .maddr_i(maddr_i), .wreg_i(wreg_i), .wd_i(wd_i), .wdata_i(wdata_i),
        .stallreq_o(stall16), .mreq_o(mreq16), .mwe_o(mwe16), .maddr_o(maddr16),
        .mwdata_o(mwdata16), .mbe_o(mbe16), .mack_i(mack16), .mrdata_i(mrdata16),
        .valid_o(valid16), .wreg_o(wreg16), .wd_o(wd16), .wdata_o(wdata16),
        .wreg_f(wregf16), .wd_f(wdf16), .wdata_f(wdataf16), .excp_o(excp16));

    // Memory model: 8-bit port acks after dly8 waiting cycles, 16-bit port acks at once
    always_comb begin
        mack8    = (mreq8 && wait8 >= dly8) || force8;
        mrdata8  = mem[maddr8[9:0]];
        mack16   = mreq16;
        mrdata16 = {mem[maddr16[9:0] + 10'd1], mem[maddr16[9:0]]};
    end

    always @(posedge clk) begin
        wait8 <= (mreq8 && !mack8) ? wait8 + 1 : 0;
        if (mreq8 && mack8 && mwe8) wmem[maddr8[9:0]] <= mwdata8;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic a8, input logic a16, input logic [2:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic wr, input logic [4:0] wd, input logic [31:0] d);
        v8 = a8; v16 = a16; aluop_i = op; f3_i = f3; maddr_i = a; wreg_i = wr; wd_i = wd; wdata_i = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] sw;
        sw = 32'hAABBCCDD;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
        mem[10'h104] = 8'hEF; mem[10'h105] = 8'hBE;
        mem[10'h201] = 8'h80; mem[10'h202] = 8'h55;
        drive(1'b1, 1'b1, OP_LOAD, F3_W, 32'h100, 1'b1, 5'd1, 32'h0);
        repeat (2) smp();
        chk("rst_mreq", {31'd0, mreq8}, 32'd0);
        chk("rst_maddr", maddr8, 32'd0);
        chk("rst_mbe", {31'd0, mbe8}, 32'd0);
        chk("rst_valid", {31'd0, valid8}, 32'd0);
        chk("rst_wdata", wdata8, 32'd0);
        chk("rst_excp", {31'd0, excp8}, 32'd0);
        chk("rst_mreq16", {31'd0, mreq16}, 32'd0);
        drive(1'b0, 1'b0, OP_OTHER, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        rst = 1'b1;
        // 1: LW over a byte bus, ack every cycle
        step();
        drive(1'b1, 1'b0, OP_LOAD, F3_W, 32'h100, 1'b1, 5'd3, 32'h0);
        for (int k = 0; k < 4; k++) begin
            smp();
            chk($sformatf("lw_mreq%0d", k), {31'd0, mreq8}, 32'd1);
            chk($sformatf("lw_addr%0d", k), maddr8, 32'h100 + k);
            chk($sformatf("lw_mbe%0d", k), {31'd0, mbe8}, 32'd1);
            chk($sformatf("lw_stall%0d", k), {31'd0, stall8}, (k < 3) ? 32'd1 : 32'd0);
            chk($sformatf("lw_bubble%0d", k), {31'd0, valid8}, 32'd0);
            step();
        end
        drive(1'b0, 1'b0, OP_OTHER, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        smp();
        chk("lw_valid", {31'd0, valid8}, 32'd1);
        chk("lw_wdata", wdata8, 32'h12345678);
        chk("lw_wd", {27'd0, wd8}, 32'd3);
        chk("lw_wregf", {31'd0, wregf8}, 32'd1);
        // 2: LB / LBU over a 16-bit bus at an odd address
        step();
        drive(1'b0, 1'b1, OP_LOAD, F3_B, 32'h201, 1'b1, 5'd4, 32'h0);
        smp();
        chk("lb_mreq", {31'd0, mreq16}, 32'd1);
        chk("lb_addr", maddr16, 32'h201);
        chk("lb_mbe", {30'd0, mbe16}, 32'd1);
        chk("lb_stall", {31'd0, stall16}, 32'd0);
        step();
        drive(1'b0, 1'b1, OP_LOAD, F3_BU, 32'h201, 1'b1, 5'd4, 32'h0);
        smp();
        chk("lb_wdata", wdata16, 32'hFFFFFF80);
        chk("lb_valid", {31'd0, valid16}, 32'd1);
        step();
        drive(1'b0, 1'b0, OP_OTHER, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        smp();
        chk("lbu_wdata", wdata16, 32'h00000080);
        // 3: SW with two wait cycles per beat
        dly8 = 2;
        step();
        drive(1'b1, 1'b0, OP_STORE, F3_W, 32'h40, 1'b1, 5'd9, 32'hAABBCCDD);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) begin
                smp();
                chk($sformatf("sw_mreq%0d_%0d", k, c), {31'd0, mreq8}, 32'd1);
                chk($sformatf("sw_mwe%0d_%0d", k, c), {31'd0, mwe8}, 32'd1);
                chk($sformatf("sw_addr%0d_%0d", k, c), maddr8, 32'h40 + k);
                chk($sformatf("sw_data%0d_%0d", k, c), {24'd0, mwdata8}, {24'd0, sw[8*k +: 8]});
                chk($sformatf("sw_stall%0d_%0d", k, c), {31'd0, stall8}, (k == 3 && c == 2) ? 32'd0 : 32'd1);
                step();
            end
        end
        drive(1'b0, 1'b0, OP_OTHER, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        dly8 = 0;
        smp();
        chk("sw_valid", {31'd0, valid8}, 32'd1);
        chk("sw_wreg", {31'd0, wreg8}, 32'd0);
        chk("sw_mem", {wmem[10'h43], wmem[10'h42], wmem[10'h41], wmem[10'h40]}, 32'hAABBCCDD);
        // 4: LH followed back-to-back by ADD
        step();
        drive(1'b1, 1'b0, OP_LOAD, F3_H, 32'h100, 1'b1, 5'd6, 32'h0);
        smp();
        chk("lh_stall0", {31'd0, stall8}, 32'd1);
        step();
        smp();
        chk("lh_stall1", {31'd0, stall8}, 32'd0);
        step();
        drive(1'b1, 1'b0, OP_OTHER, 3'd0, 32'h0, 1'b1, 5'd5, 32'd7);
        smp();
        chk("lh_valid", {31'd0, valid8}, 32'd1);
        chk("lh_wdata", wdataf8, 32'h00005678);
        chk("lh_wdf", {27'd0, wdf8}, 32'd6);
        chk("lh_wregf", {31'd0, wregf8}, 32'd1);
        chk("add_stall", {31'd0, stall8}, 32'd0);
        step();
        drive(1'b0, 1'b0, OP_OTHER, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        smp();
        chk("add_valid", {31'd0, valid8}, 32'd1);
        chk("add_wdata", wdataf8, 32'd7);
        chk("add_wdf", {27'd0, wdf8}, 32'd5);
        chk("add_wregf", {31'd0, wregf8}, 32'd1);
        // Unknown funct3 on a load: no access, single-cycle, no register write
        step();
        drive(1'b1, 1'b0, OP_LOAD, 3'b011, 32'h100, 1'b1, 5'd7, 32'h33);
        smp();
        chk("bad_mreq", {31'd0, mreq8}, 32'd0);
        chk("bad_stall", {31'd0, stall8}, 32'd0);
        step();
        drive(1'b0, 1'b0, OP_OTHER, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        smp();
        chk("bad_valid", {31'd0, valid8}, 32'd1);
        chk("bad_wreg", {31'd0, wreg8}, 32'd0);
        // 5: reset during the second beat of an LW
        step();
        drive(1'b1, 1'b0, OP_LOAD, F3_W, 32'h100, 1'b1, 5'd8, 32'h0);
        step();
        #2;
        chk("rb_mreq_pre", {31'd0, mreq8}, 32'd1);
        chk("rb_addr_pre", maddr8, 32'h101);
        rst = 1'b0;
        #1;
        chk("rb_mreq", {31'd0, mreq8}, 32'd0);
        chk("rb_maddr", maddr8, 32'd0);
        chk("rb_mbe", {31'd0, mbe8}, 32'd0);
        chk("rb_stall", {31'd0, stall8}, 32'd0);
        chk("rb_valid", {31'd0, valid8}, 32'd0);
        chk("rb_wdata", wdata8, 32'd0);
        drive(1'b0, 1'b0, OP_OTHER, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        rst = 1'b1;
        force8 = 1'b1;
        smp();
        chk("rb_late_mreq", {31'd0, mreq8}, 32'd0);
        step();
        force8 = 1'b0;
        smp();
        chk("rb_late_valid", {31'd0, valid8}, 32'd0);
        chk("rb_late_wregf", {31'd0, wregf8}, 32'd0);
        // 6: LW at a misaligned address
        step();
        drive(1'b1, 1'b0, OP_LOAD, F3_W, 32'h102, 1'b1, 5'd10, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        smp();
        chk("mis_mreq", {31'd0, mreq8}, 32'd0);
        chk("mis_stall", {31'd0, stall8}, 32'd0);
        step();
        drive(1'b0, 1'b0, OP_OTHER, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        smp();
        chk("mis_excp", {31'd0, excp8}, 32'd1);
        chk("mis_valid", {31'd0, valid8}, 32'd1);
        chk("mis_wreg", {31'd0, wreg8}, 32'd0);
`else
        for (int k = 0; k < 4; k++) begin
            smp();
            chk($sformatf("mis_addr%0d", k), maddr8, 32'h102 + k);
            step();
        end
        drive(1'b0, 1'b0, OP_OTHER, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        smp();
        chk("mis_wdata", wdata8, 32'hBEEF1234);
        chk("mis_excp", {31'd0, excp8}, 32'd0);
        chk("mis_wreg", {31'd0, wreg8}, 32'd1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
